// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler/period timebase, per-channel double-buffered duty.
// Optional up/down (center-aligned) counting is built when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi_ch #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             en_i,
    input  logic             pol_i,
    output logic             pwm_o
);
    logic pwm_q, pwm_d, raw;

    assign raw   = (cnt_i < duty_i);
    assign pwm_d = en_i ? (raw ^ pol_i) : pol_i;

    // Cleared to 0 in reset regardless of polarity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_q <= 1'b0;
        else      pwm_q <= pwm_d;
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 11,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        period,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       polarity,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                    center,
`endif
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    cycle_start,
    output logic                    pending
);
    typedef logic [NUM_CH-1:0][WIDTH-1:0] duty_arr_t;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   period_act_q, period_act_d;
    logic [WIDTH-1:0]   period_pend_q, period_pend_d;
    duty_arr_t          duty_act_q, duty_act_d;
    duty_arr_t          duty_pend_q, duty_pend_d;
    logic               pending_q, pending_d;
    logic               cycle_start_q;
    logic               tick, boundary;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP, DIR_DN} dir_e;
    dir_e dir_q, dir_d;
    logic center_q, center_d;
`endif

    // Timebase: prescaler and period counter.
    always_comb begin
        tick        = (presc_cnt_q >= prescale);
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = cnt_q;
        boundary    = 1'b0;
        if (tick) begin
            if (cnt_q >= period_act_q) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef PWM_CENTER_ALIGN_EN
        dir_d = dir_q;
        if (!center_q) begin
            dir_d = DIR_UP;
        end else if (tick) begin
            // Top of the triangle counts as the first down step; valley is the boundary.
            boundary = 1'b0;
            if (dir_q == DIR_DN || cnt_q >= period_act_q) begin
                if (cnt_q <= WIDTH'(1)) begin
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = DIR_DN;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        center_d = boundary ? center : center_q;
`endif
    end

    // Shadow registers: a load coinciding with a boundary bypasses the pending stage.
    always_comb begin
        period_act_d  = period_act_q;
        duty_act_d    = duty_act_q;
        period_pend_d = period_pend_q;
        duty_pend_d   = duty_pend_q;
        pending_d     = pending_q;
        if (boundary && load) begin
            period_act_d = period;
            duty_act_d   = duty_arr_t'(duty);
            pending_d    = 1'b0;
        end else begin
            if (boundary && pending_q) begin
                period_act_d = period_pend_q;
                duty_act_d   = duty_pend_q;
                pending_d    = 1'b0;
            end
            if (load) begin
                period_pend_d = period;
                duty_pend_d   = duty_arr_t'(duty);
                pending_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt_q   <= '0;
            cnt_q         <= '0;
            period_act_q  <= '1;
            period_pend_q <= '0;
            duty_act_q    <= '0;
            duty_pend_q   <= '0;
            pending_q     <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            presc_cnt_q   <= presc_cnt_d;
            cnt_q         <= cnt_d;
            period_act_q  <= period_act_d;
            period_pend_q <= period_pend_d;
            duty_act_q    <= duty_act_d;
            duty_pend_q   <= duty_pend_d;
            pending_q     <= pending_d;
            cycle_start_q <= boundary;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q    <= DIR_UP;
            center_q <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            center_q <= center_d;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_multi_ch #(.WIDTH(WIDTH)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .cnt_i  (cnt_q),
            .duty_i (duty_act_q[i]),
            .en_i   (ch_en[i]),
            .pol_i  (polarity[i]),
            .pwm_o  (pwm_out[i])
        );
    end

    assign cycle_start = cycle_start_q;
    assign pending     = pending_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (edge-aligned mode).
module tb_pwm_multi;
    localparam int NUM_CH = 4, WIDTH = 11, PRESC_W = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [WIDTH-1:0]        period = '0;
    logic [PRESC_W-1:0]      prescale = '0;
    logic [NUM_CH*WIDTH-1:0] duty = '0;
    logic                    load = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH-1:0]       polarity = '0;
    logic                    center = 1'b0;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    cycle_start;
    logic                    pending;

    int checks = 0;
    int errors = 0;
    logic [31:0] cap_pw [NUM_CH];
    logic [31:0] cap_cs, cap_pd;

    pwm_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .period      (period),
        .prescale    (prescale),
        .duty        (duty),
        .load        (load),
        .ch_en       (ch_en),
        .polarity    (polarity),
`ifdef PWM_CENTER_ALIGN_EN
        .center      (center),
`endif
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic set_duty(input int d3, input int d2, input int d1, input int d0);
        duty = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic sync_cs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cycle_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Records n samples following the current negedge; load is raised after sample load_k.
    task automatic capture(input int n, input int load_k);
        cap_cs = '0;
        cap_pd = '0;
        for (int c = 0; c < NUM_CH; c++) cap_pw[c] = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) cap_pw[c][k] = pwm_out[c];
            cap_cs[k] = cycle_start;
            cap_pd[k] = pending;
            load = (k == load_k);
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        polarity = '1;
        ch_en = '1;
        repeat (2) @(negedge clk);
        checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL rst_pwm got %b exp 0000", pwm_out); end
        checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", cycle_start); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pend got %b exp 0", pending); end
        polarity = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL rst_rel_pwm got %b exp 0000", pwm_out); end
    endtask

    task automatic test_basic();
        bit ok;
        prescale = 8'd0;
        period = 11'd9;
        set_duty(0, 0, 0, 3);
        pulse_load();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pend got %b exp 1", pending); end
        sync_cs(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_sync got timeout exp cycle_start"); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL basic_pend_clr got %b exp 0", pending); end
        for (int r = 0; r < 2; r++) begin
            capture(10, -1);
            checks++; if (cap_pw[0] !== 32'h007) begin errors++; $display("FAIL basic_pw%0d got %h exp 007", r, cap_pw[0]); end
            checks++; if (cap_cs !== 32'h200) begin errors++; $display("FAIL basic_cs%0d got %h exp 200", r, cap_cs); end
        end
    endtask

    task automatic test_full_scale();
        bit ok;
        set_duty(0, 0, 10, 0);
        pulse_load();
        sync_cs(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_sync got timeout exp cycle_start"); end
        for (int r = 0; r < 2; r++) begin
            capture(10, -1);
            checks++; if (cap_pw[0] !== 32'h000) begin errors++; $display("FAIL full_ch0_%0d got %h exp 000", r, cap_pw[0]); end
            checks++; if (cap_pw[1] !== 32'h3FF) begin errors++; $display("FAIL full_ch1_%0d got %h exp 3ff", r, cap_pw[1]); end
            checks++; if (cap_cs !== 32'h200) begin errors++; $display("FAIL full_cs%0d got %h exp 200", r, cap_cs); end
        end
    endtask

    task automatic test_shadow();
        bit ok;
        set_duty(0, 0, 0, 3);
        pulse_load();
        sync_cs(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL shadow_sync got timeout exp cycle_start"); end
        set_duty(0, 0, 0, 7);
        capture(10, 4);
        checks++; if (cap_pw[0] !== 32'h007) begin errors++; $display("FAIL shadow_old got %h exp 007", cap_pw[0]); end
        checks++; if (cap_pd !== 32'h1E0) begin errors++; $display("FAIL shadow_pend got %h exp 1e0", cap_pd); end
        checks++; if (cap_cs !== 32'h200) begin errors++; $display("FAIL shadow_cs got %h exp 200", cap_cs); end
        capture(10, -1);
        checks++; if (cap_pw[0] !== 32'h07F) begin errors++; $display("FAIL shadow_new got %h exp 07f", cap_pw[0]); end
        checks++; if (cap_pd !== 32'h000) begin errors++; $display("FAIL shadow_pend2 got %h exp 000", cap_pd); end
    endtask

    task automatic test_prescale();
        bit ok;
        prescale = 8'd1;
        set_duty(0, 0, 0, 4);
        pulse_load();
        sync_cs(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL presc_sync got timeout exp cycle_start"); end
        capture(20, -1);
        checks++; if (cap_pw[0] !== 32'h000FF) begin errors++; $display("FAIL presc_pw got %h exp 000ff", cap_pw[0]); end
        checks++; if (cap_cs !== 32'h80000) begin errors++; $display("FAIL presc_cs got %h exp 80000", cap_cs); end
    endtask

    task automatic test_polarity();
        bit ok;
        prescale = 8'd0;
        set_duty(0, 3, 0, 3);
        polarity = 4'b0100;
        ch_en = 4'b1011;
        pulse_load();
        sync_cs(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pol_sync got timeout exp cycle_start"); end
        capture(10, -1);
        checks++; if (cap_pw[2] !== 32'h3FF) begin errors++; $display("FAIL pol_idle got %h exp 3ff", cap_pw[2]); end
        checks++; if (cap_pw[0] !== 32'h007) begin errors++; $display("FAIL pol_ch0 got %h exp 007", cap_pw[0]); end
        ch_en = 4'b1111;
        capture(10, -1);
        checks++; if (cap_pw[2] !== 32'h3F8) begin errors++; $display("FAIL pol_inv got %h exp 3f8", cap_pw[2]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hi;
        logic [NUM_CH-1:0] acc_pw;
        logic acc_cs;
        polarity = '0;
        @(negedge clk);
        checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", pwm_out[0]); end
        #2 rst = 1'b0;
        #1;
        checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL mid_async got %b exp 0000", pwm_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acc_pw = '0;
        acc_cs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc_pw |= pwm_out;
            acc_cs |= cycle_start;
        end
        checks++; if (acc_pw !== 4'b0000) begin errors++; $display("FAIL mid_idle got %b exp 0000", acc_pw); end
        checks++; if (acc_cs !== 1'b0) begin errors++; $display("FAIL mid_cs got %b exp 0", acc_cs); end
        period = 11'd9;
        set_duty(0, 0, 0, 3);
        pulse_load();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pend got %b exp 1", pending); end
        hi = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pwm_out !== 4'b0000) hi++;
            if (cycle_start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_sync got timeout exp cycle_start"); end
        checks++; if (hi != 0) begin errors++; $display("FAIL mid_wait_hi got %0d exp 0", hi); end
        capture(10, -1);
        checks++; if (cap_pw[0] !== 32'h007) begin errors++; $display("FAIL mid_pw got %h exp 007", cap_pw[0]); end
        checks++; if (cap_cs !== 32'h200) begin errors++; $display("FAIL mid_cs2 got %h exp 200", cap_cs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_shadow();
        test_prescale();
        test_polarity();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
